// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared constants, FSM states and write-buffer entry for the boot loader
package boot_loader_pkg;

    localparam logic [8:0] ROM_OS_ADDR     = 9'h000;
    localparam logic [8:0] ROM_BASIC_ADDR  = 9'h100;
    localparam logic [8:0] ROM_AMSDOS_ADDR = 9'h107;
    localparam logic [8:0] ROM_MF2_ADDR    = 9'h0FF;

    localparam logic [7:0] IDX_SYS = 8'd0;
    localparam logic [7:0] IDX_CPR = 8'd5;
    localparam logic [7:0] IDX_BIN = 8'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_t;

    typedef struct packed {
        logic [8:0]  page;
        logic [13:0] offset;
        logic [7:0]  data;
        logic [1:0]  bank;
        logic        dup;
    } entry_t;

    function automatic logic [8:0] sys_page(input logic [1:0] blk);
        case (blk)
            2'd0:    return ROM_OS_ADDR;
            2'd1:    return ROM_BASIC_ADDR;
            2'd2:    return ROM_AMSDOS_ADDR;
            default: return ROM_MF2_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/boot_wr_fifo.sv
// rtl/boot_wr_fifo.sv - synchronous write-buffer FIFO with occupancy count
module boot_wr_fifo
    import boot_loader_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - ioctl download to SDRAM sequencer; PLUS_CART_EN enables CPR/BIN indices
module boot_loader_ctrl
    import boot_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int SYS_BLOCKS = 4
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         ce_ref,
    input  logic         ioctl_download,
    input  logic         ioctl_wr,
    input  logic [24:0]  ioctl_addr,
    input  logic [7:0]   ioctl_dout,
    input  logic [7:0]   ioctl_index,
    input  logic [8:0]   page_base,
    output logic         ioctl_wait,
    output logic         boot_wr,
    output logic [22:0]  boot_a,
    output logic [1:0]   boot_bank,
    output logic [7:0]   boot_dout,
    output logic [255:0] rom_map,
    output logic         rom_loaded,
    output logic         core_reset
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_CNT = CW'(FIFO_DEPTH - 1);

    state_t         state;
    state_t         state_next;
    entry_t         head;
    entry_t         push_entry;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  count_next;
    logic           fifo_full;
    logic           fifo_empty;
    logic           dl_prev;
    logic           done_armed;
    logic [8:0]     page_reg;
    logic [8:0]     page_eff;
    logic [10:0]    blk;
    logic           dl_rise;
    logic           dl_fall;
    logic           accept;
    logic           decode_ok;
    logic           push;
    logic           pop;
    logic           load;
    logic           to_bank1;
    logic           map_set;

    assign dl_rise  = ioctl_download && !dl_prev;
    assign dl_fall  = !ioctl_download && dl_prev;
    assign accept   = ioctl_download && ioctl_wr;
    assign blk      = ioctl_addr[24:14];
    // A byte arriving on the start cycle must already see the new page base.
    assign page_eff = dl_rise ? page_base : page_reg;
    assign push     = accept && decode_ok && !fifo_full;

    always_comb begin
        push_entry        = '0;
        decode_ok         = 1'b0;
        push_entry.offset = ioctl_addr[13:0];
        push_entry.data   = ioctl_dout;
        if (ioctl_index == IDX_SYS) begin
            if ((32'(blk) < 32'(SYS_BLOCKS)) && (blk < 11'd4)) begin
                decode_ok       = 1'b1;
                push_entry.page = sys_page(blk[1:0]);
            end
        end else if (ioctl_index[4:0] >= 5'd1 && ioctl_index[4:0] <= 5'd3) begin
            decode_ok       = 1'b1;
            push_entry.page = {page_eff[8], page_eff[7:0] + ioctl_addr[21:14]};
            push_entry.bank = {1'b0, &ioctl_index[7:6]};
            push_entry.dup  = (ioctl_index[7:6] == 2'b01 || ioctl_index[5:0] != 6'd0)
                              && !(&ioctl_index[7:6]);
        end
`ifdef PLUS_CART_EN
        else if (ioctl_index == IDX_CPR || ioctl_index == IDX_BIN) begin
            decode_ok       = 1'b1;
            push_entry.page = {1'b1, ioctl_addr[21:14]};
        end
`endif
    end

    always_comb begin
        count_next = fifo_count;
        if (push && !pop)      count_next = fifo_count + 1'b1;
        else if (pop && !push) count_next = fifo_count - 1'b1;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        to_bank1   = 1'b0;
        map_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = WR0;
                end
            end
            WR0: begin
                if (ce_ref) begin
                    if (head.dup) begin
                        to_bank1   = 1'b1;
                        state_next = WR1;
                    end else begin
                        pop        = 1'b1;
                        map_set    = boot_a[22];
                        state_next = IDLE;
                    end
                end
            end
            WR1: begin
                if (ce_ref) begin
                    pop        = 1'b1;
                    map_set    = boot_a[22];
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            dl_prev    <= 1'b0;
            done_armed <= 1'b0;
            page_reg   <= '0;
            ioctl_wait <= 1'b0;
            boot_wr    <= 1'b0;
            boot_a     <= '0;
            boot_bank  <= '0;
            boot_dout  <= '0;
            rom_map    <= '0;
            rom_loaded <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            state      <= state_next;
            dl_prev    <= ioctl_download;
            ioctl_wait <= (count_next >= WAIT_CNT);
            if (dl_rise) page_reg <= page_base;
            if (load) begin
                boot_wr   <= 1'b1;
                boot_a    <= {head.page, head.offset};
                boot_bank <= head.bank;
                boot_dout <= head.data;
            end
            if (to_bank1) boot_bank <= 2'd1;
            if (pop)      boot_wr <= 1'b0;
            if (map_set)  rom_map[boot_a[21:14]] <= 1'b1;
            if (dl_rise) begin
                done_armed <= 1'b0;
                rom_loaded <= 1'b0;
                core_reset <= 1'b1;
            end else if (dl_fall) begin
                done_armed <= 1'b1;
            end else if (done_armed && fifo_empty && state == IDLE) begin
                done_armed <= 1'b0;
                rom_loaded <= 1'b1;
                core_reset <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset && accept && decode_ok) assert (!fifo_full);
    end

    boot_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_sys),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - directed self-checking bench for boot_loader_ctrl
module tb_boot_loader_ctrl;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic         ce_ref;
    logic         ioctl_download;
    logic         ioctl_wr;
    logic [24:0]  ioctl_addr;
    logic [7:0]   ioctl_dout;
    logic [7:0]   ioctl_index;
    logic [8:0]   page_base;
    logic         ioctl_wait;
    logic         boot_wr;
    logic [22:0]  boot_a;
    logic [1:0]   boot_bank;
    logic [7:0]   boot_dout;
    logic [255:0] rom_map;
    logic         rom_loaded;
    logic         core_reset;

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    logic [32:0]  cap_q[$];
    int           cap_cyc[$];
    logic         wait_seen = 1'b0;
    logic [255:0] exp_map;

    boot_loader_ctrl dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce_ref         (ce_ref),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .page_base      (page_base),
        .ioctl_wait     (ioctl_wait),
        .boot_wr        (boot_wr),
        .boot_a         (boot_a),
        .boot_bank      (boot_bank),
        .boot_dout      (boot_dout),
        .rom_map        (rom_map),
        .rom_loaded     (rom_loaded),
        .core_reset     (core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        ce_ref = 1'b0;
        forever begin
            repeat (7) @(posedge clk_sys);
            #1 ce_ref = 1'b1;
            @(posedge clk_sys);
            #1 ce_ref = 1'b0;
        end
    end

    // Records every write the SDRAM slot consumes at the coming edge.
    always @(negedge clk_sys) begin
        if (!reset && boot_wr && ce_ref) begin
            cap_q.push_back({boot_a, boot_bank, boot_dout});
            cap_cyc.push_back(cyc);
        end
        if (ioctl_wait) wait_seen = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx, input logic [8:0] pb);
        tick();
        ioctl_index    = idx;
        page_base      = pb;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic send_stream(input logic [24:0] a0, input logic [7:0] d0, input int n);
        int i = 0;
        int g = 0;
        while (i < n && g < 400) begin
            if (!ioctl_wait) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = a0 + 25'(i);
                ioctl_dout = d0 + 8'(i);
                i++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
            g++;
        end
        ioctl_wr = 1'b0;
        check("stream_sent", 256'(i), 256'(n));
    endtask

    task automatic wait_writes(input int n, input string tag);
        int g = 0;
        while (cap_q.size() < n && g < 300) begin
            @(negedge clk_sys);
            g++;
        end
        check(tag, 256'(cap_q.size()), 256'(n));
    endtask

    task automatic end_dl(input string tag);
        int g = 0;
        ioctl_download = 1'b0;
        while (!rom_loaded && g < 300) begin
            tick();
            g++;
        end
        @(negedge clk_sys);
        check({tag, "_loaded"}, 256'(rom_loaded), 256'd1);
        check({tag, "_core_reset"}, 256'(core_reset), 256'd0);
    endtask

    initial begin
        int g;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        page_base      = '0;
        repeat (3) tick();
        @(negedge clk_sys);
        check("rst_wait", 256'(ioctl_wait), 256'd0);
        check("rst_boot_wr", 256'(boot_wr), 256'd0);
        check("rst_boot_a", 256'(boot_a), 256'd0);
        check("rst_rom_map", rom_map, 256'd0);
        check("rst_rom_loaded", 256'(rom_loaded), 256'd0);
        check("rst_core_reset", 256'(core_reset), 256'd1);
        tick();
        reset = 1'b0;

        // system ROM block 1 -> BASIC page 0x100
        cap_q.delete(); cap_cyc.delete();
        start_dl(8'h00, 9'h000);
        @(negedge clk_sys);
        check("t1_core_reset_held", 256'(core_reset), 256'd1);
        send_stream(25'h04000, 8'hA0, 4);
        wait_writes(4, "t1_count");
        end_dl("t1");
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_wr%0d", i), 256'(cap_q[i]),
                  256'({23'h400000 + 23'(i), 2'd0, 8'hA0 + 8'(i)}));
        check("t1_nwrites", 256'(cap_q.size()), 256'd4);
        exp_map = 256'h1;
        check("t1_rom_map", rom_map, exp_map);

        // block 4 is beyond SYS_BLOCKS
        cap_q.delete(); cap_cyc.delete();
        start_dl(8'h00, 9'h000);
        @(negedge clk_sys);
        check("t2_loaded_cleared", 256'(rom_loaded), 256'd0);
        send_stream(25'h10000, 8'h77, 1);
        repeat (20) tick();
        check("t2_no_write", 256'(cap_q.size()), 256'd0);
        end_dl("t2");

        // duplicated write into bank 1
        cap_q.delete(); cap_cyc.delete();
        start_dl(8'h41, 9'h1F0);
        send_stream(25'h08005, 8'h5A, 1);
        wait_writes(2, "t3_count");
        check("t3_bank0", 256'(cap_q[0]), 256'({23'h7C8005, 2'd0, 8'h5A}));
        check("t3_bank1", 256'(cap_q[1]), 256'({23'h7C8005, 2'd1, 8'h5A}));
        check("t3_slot_gap", 256'(cap_cyc[1] - cap_cyc[0]), 256'd8);
        end_dl("t3");
        exp_map = exp_map | (256'h1 << 8'hF2);
        check("t3_rom_map", rom_map, exp_map);

        // back-to-back bytes with backpressure
        cap_q.delete(); cap_cyc.delete();
        wait_seen = 1'b0;
        start_dl(8'h00, 9'h000);
        send_stream(25'h00000, 8'h10, 6);
        wait_writes(6, "t4_count");
        for (int i = 0; i < 6; i++)
            check($sformatf("t4_wr%0d", i), 256'(cap_q[i]),
                  256'({23'(i), 2'd0, 8'h10 + 8'(i)}));
        for (int i = 1; i < 6; i++)
            check($sformatf("t4_gap%0d", i), 256'(cap_cyc[i] - cap_cyc[i-1]), 256'd8);
        check("t4_wait_seen", 256'(wait_seen), 256'd1);
        end_dl("t4");
        check("t4_rom_map", rom_map, exp_map);

        // reset while a write is pending
        cap_q.delete(); cap_cyc.delete();
        start_dl(8'h00, 9'h000);
        g = 0;
        while (!ce_ref && g < 20) begin @(negedge clk_sys); g++; end
        tick();
        send_stream(25'h04010, 8'hAA, 1);
        g = 0;
        @(negedge clk_sys);
        while (!(boot_wr && !ce_ref) && g < 20) begin @(negedge clk_sys); g++; end
        check("t5_pending", 256'(boot_wr), 256'd1);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        check("t5_boot_wr", 256'(boot_wr), 256'd0);
        check("t5_boot_a", 256'(boot_a), 256'd0);
        check("t5_boot_bank", 256'(boot_bank), 256'd0);
        check("t5_boot_dout", 256'(boot_dout), 256'd0);
        check("t5_rom_map", rom_map, 256'd0);
        check("t5_rom_loaded", 256'(rom_loaded), 256'd0);
        check("t5_core_reset", 256'(core_reset), 256'd1);
        check("t5_wait", 256'(ioctl_wait), 256'd0);
        check("t5_aborted", 256'(cap_q.size()), 256'd0);
        cap_q.delete(); cap_cyc.delete();
        start_dl(8'h00, 9'h000);
        send_stream(25'h04010, 8'hAA, 1);
        wait_writes(1, "t5_count");
        check("t5_restart_wr", 256'(cap_q[0]), 256'({23'h400010, 2'd0, 8'hAA}));
        end_dl("t5");
        exp_map = 256'h1;
        check("t5_restart_map", rom_map, exp_map);

        // cartridge index 5
        cap_q.delete(); cap_cyc.delete();
        start_dl(8'h05, 9'h000);
        send_stream(25'h0C001, 8'hC3, 1);
`ifdef PLUS_CART_EN
        wait_writes(1, "t6_count");
        check("t6_wr", 256'(cap_q[0]), 256'({23'h40C001, 2'd0, 8'hC3}));
        exp_map = exp_map | (256'h1 << 3);
`else
        repeat (30) tick();
        check("t6_no_write", 256'(cap_q.size()), 256'd0);
`endif
        end_dl("t6");
        check("t6_rom_map", rom_map, exp_map);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
Sequences the ioctl download byte stream into the shared SDRAM CPU port while the core is held in reset. It maps system ROM blocks to fixed SDRAM pages and offsets expansion ROMs by a page base. Where required it duplicates each write into bank 1, and it maintains the 256-bit rom_map. It applies ioctl_wait backpressure when its 2-entry buffer is full, and it releases core reset only once the final byte has been committed.

Parameters:
FIFO_DEPTH, 2, write-buffer entries (power of two, minimum 2)
SYS_BLOCKS, 4, number of 16 KB system ROM blocks accepted when ioctl_index==0

Ports:
clk_sys  in  1  system clock (48 MHz)
reset  in  1  synchronous, active-high
ce_ref  in  1  SDRAM slot strobe, one clk_sys cycle in 8
ioctl_download  in  1  download active
ioctl_wr  in  1  byte valid strobe
ioctl_addr  in  25  byte address within file
ioctl_dout  in  8  byte data
ioctl_index  in  8  file index/type
page_base  in  9  expansion ROM page base, sampled at download start
ioctl_wait  out  1  backpressure to ioctl source
boot_wr  out  1  SDRAM write request
boot_a  out  23  SDRAM address {page[8:0], offset[13:0]}
boot_bank  out  2  SDRAM bank
boot_dout  out  8  SDRAM write data
rom_map  out  256  page-populated flags for boot_a[22]==1 pages
rom_loaded  out  1  level; set when a download completes and the buffer is drained
core_reset  out  1  reset to motherboard/SDRAM mux; high until rom_loaded

Behaviour:
- Reset values: ioctl_wait=0, boot_wr=0, boot_a=0, boot_bank=0, boot_dout=0, rom_map=0, rom_loaded=0, core_reset=1. FIFO is emptied, page register=0, FSM=IDLE. Reset mid-download aborts everything, including a pending boot_wr.
- Download start: the rising edge of ioctl_download latches page_base into the page register and clears rom_loaded. core_reset is forced to 1.
- Accept (cycle of ioctl_wr=1 with ioctl_download=1), applied in order:
  1. If the FIFO is full, the byte is dropped and flagged in sim via an assertion. The source must honour ioctl_wait.
  2. ioctl_index==0:
     - Block k=ioctl_addr[24:14] maps to page 0→9'h000, 1→9'h100, 2→9'h107, 3→9'h0FF.
     - k≥SYS_BLOCKS is discarded silently.
     - bank is 0 and dup is 0.
  3. ioctl_index[4:0] in 1..3:
     - page = {page[8], page[7:0]+ioctl_addr[21:14]}; the 8-bit add wraps mod 256.
     - bank = {0, &ioctl_index[7:6]}.
     - dup = (ioctl_index[7:6]==1 || ioctl_index[5:0]!=0) && bank==0.
  4. Any other index is discarded.
  - Entry pushed: {page, ioctl_addr[13:0], data, bank, dup}.
- ioctl_wait = FIFO count ≥ FIFO_DEPTH-1, registered. It is asserted the cycle after the accept that makes the count reach that threshold.
- FSM:
  - IDLE: FIFO non-empty → load head onto boot_a/bank/dout, boot_wr=1, go to WR0.
  - WR0: hold boot_wr until a cycle with ce_ref=1, which consumes the write.
    - If dup, go to WR1 with boot_bank=1 and boot_wr held at 1.
    - Otherwise pop, set rom_map[boot_a[21:14]] if boot_a[22]==1, and go to IDLE.
  - WR1: wait for ce_ref=1, then pop, update rom_map as in WR0, and go to IDLE.
  - Back-to-back: a new head may be loaded the cycle after the pop. A minimum of one idle cycle is required between ce_ref consumptions.
- Completion:
  - Falling edge of ioctl_download arms DONE.
  - rom_loaded=1 and core_reset=0 are set on the first cycle with the FIFO empty and FSM=IDLE.
  - If a new download starts before that cycle, DONE is cancelled.
- Simultaneous push and pop on the same cycle: count is unchanged.

Optional Feature:
PLUS_CART_EN:
- Defined: ioctl_index 5 (CPR) or 6 (BIN) is accepted. page = {1'b1, ioctl_addr[21:14]}, bank=0, dup=0. rom_map is updated.
- Undefined: indices 5/6 are discarded like any other unsupported index.

Decomposition:
- Package boot_loader_pkg holds:
  - system page constants ROM_OS_ADDR=9'h000, ROM_BASIC_ADDR=9'h100, ROM_AMSDOS_ADDR=9'h107, ROM_MF2_ADDR=9'h0FF
  - index codes IDX_SYS=0, IDX_CPR=5, IDX_BIN=6
  - FSM state enum {IDLE, WR0, WR1}
  - FIFO entry struct
- Sub-module boot_wr_fifo: a synchronous FIFO with count output, holding the 2-deep buffer.

Test Plan:
1. ioctl_index=0, 4 bytes at addr 0x04000..0x04003 → four writes at boot_a=0x400000..0x400003, bank 0. rom_map[0]=1. No bank-1 writes.
2. ioctl_index=0, byte at addr 0x10000 → no boot_wr. rom_loaded=1 after the falling edge of ioctl_download.
3. ioctl_index=8'h41 (dup), page_base=9'h1F0, addr 0x08005, data 0x5A → write boot_a=0x7C8005 in bank 0, then the same address/data in bank 1, each consumed on its own ce_ref.
4. ioctl_wr on every cycle for 6 bytes → ioctl_wait asserts once count reaches 1. No byte is lost. Writes appear in order, one per ce_ref.
5. reset pulsed while boot_wr=1 mid-download → next cycle all outputs are at reset values and core_reset=1. A restarted download completes correctly.
6. With PLUS_CART_EN, ioctl_index=5, addr 0x0C001 → boot_a=0x40C001, rom_map[3]=1. Without the macro, no write occurs.
